// File: rtl/rps_round_controller.sv
// rps_round_controller: runs one Rock-Paper-Scissors round at a time.
// It collects stable player choices, then judges or forfeits the round.
// It holds the result until ack, then pulses clear_choices.
// It keeps a first-to-WIN_SCORE match score.
// Ports:
//   clk, rst_n          - clock and async active-low reset
//   start, new_match    - begin a round / zero the match (IDLE only)
//   p1_choice/p2_choice - 0 unset, 1 rock, 2 paper, 3 scissors
//   ack                 - consumer acknowledge of the result
//   clear_choices       - one-cycle pulse that resets both players
//   busy, result_valid  - status of the round
//   result, forfeit     - 0 none, 1 P1, 2 P2, 3 tie; forfeit = timeout
//   p1/p2_locked        - committed choices
//   p1/p2_score         - round wins
//   match_over          - a score reached WIN_SCORE
module rps_round_controller #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int STABLE_CYCLES  = 4,
    parameter int WIN_SCORE      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       new_match,
    input  logic [1:0] p1_choice,
    input  logic [1:0] p2_choice,
    input  logic       ack,
    output logic       clear_choices,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] result,
    output logic       forfeit,
    output logic [1:0] p1_locked,
    output logic [1:0] p2_locked,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       match_over
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [SW-1:0] CNT_ONE  = SW'(1);
    localparam logic [SW-1:0] CNT_MAX  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_JUDGE,
        S_REPORT,
        S_CLEAR
    } state_e;

    state_e state_q, state_d;

    logic [TW-1:0]         tmo_q, tmo_d;
    // Index 0 is player 1 and index 1 is player 2.
    logic [1:0][SW-1:0]    cnt_q, cnt_d;
    logic [1:0][1:0]       prev_q, prev_d;
    logic [1:0][1:0]       lock_q, lock_d;
    logic [1:0]            com_q, com_d;
    logic [1:0][3:0]       score_q, score_d;
    logic [1:0]            result_q, result_d;
    logic                  forfeit_q, forfeit_d;
    logic                  match_over_q, match_over_d;
    logic [1:0][1:0]       choice;
    logic [1:0]            win;

    assign choice = {p2_choice, p1_choice};

    // a beats b when a == (b mod 3) + 1
    function automatic logic beats(input logic [1:0] a,
                                   input logic [1:0] b);
        logic r;
        case (b)
            2'd1:    r = (a == 2'd2);
            2'd2:    r = (a == 2'd3);
            2'd3:    r = (a == 2'd1);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        lock_d       = lock_q;
        com_d        = com_q;
        score_d      = score_q;
        result_d     = result_q;
        forfeit_d    = forfeit_q;
        match_over_d = match_over_q;
        win          = 2'b00;

        unique case (state_q)
            S_IDLE: begin
                if (new_match) begin
                    score_d      = '0;
                    match_over_d = 1'b0;
                end else if (start && !match_over_q) begin
                    state_d   = S_COLLECT;
                    tmo_d     = '0;
                    cnt_d     = '0;
                    prev_d    = '0;
                    lock_d    = '0;
                    com_d     = '0;
                    result_d  = 2'd0;
                    forfeit_d = 1'b0;
                end
            end

            S_COLLECT: begin
                tmo_d = tmo_q + 1'b1;
                for (int i = 0; i < 2; i++) begin
                    // Committed choices are frozen for the round.
                    if (!com_q[i]) begin
                        prev_d[i] = choice[i];
                        if (choice[i] == 2'd0) begin
                            cnt_d[i] = '0;
                        end else if (choice[i] == prev_q[i]) begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end else begin
                            cnt_d[i] = CNT_ONE;
                        end
                        if (cnt_d[i] == CNT_MAX) begin
                            com_d[i]  = 1'b1;
                            lock_d[i] = choice[i];
                        end
                    end
                end

                if (&com_q) begin
                    state_d = S_JUDGE;
                end else if (tmo_q == TMO_LAST) begin
                    // A commit landing on the expiry cycle still judges.
                    if (&com_d) begin
                        state_d = S_JUDGE;
                    end else begin
                        state_d   = S_REPORT;
                        forfeit_d = 1'b1;
                        win       = com_d;
                        if (com_d[0]) begin
                            result_d = 2'd1;
                        end else if (com_d[1]) begin
                            result_d = 2'd2;
                        end else begin
                            result_d = 2'd0;
                        end
                    end
                end
            end

            S_JUDGE: begin
                state_d = S_REPORT;
                unique case (1'b1)
                    (lock_q[0] == lock_q[1]): begin
                        result_d = 2'd3;
                    end
                    beats(lock_q[0], lock_q[1]): begin
                        result_d = 2'd1;
                        win      = 2'b01;
                    end
                    default: begin
                        result_d = 2'd2;
                        win      = 2'b10;
                    end
                endcase
            end

            S_REPORT: begin
                if (ack) begin
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int i = 0; i < 2; i++) begin
            if (win[i]) begin
                if (score_q[i] != WIN) begin
                    score_d[i] = score_q[i] + 4'd1;
                end
                if (score_d[i] == WIN) begin
                    match_over_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            lock_q       <= '0;
            com_q        <= '0;
            score_q      <= '0;
            result_q     <= 2'd0;
            forfeit_q    <= 1'b0;
            match_over_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            lock_q       <= lock_d;
            com_q        <= com_d;
            score_q      <= score_d;
            result_q     <= result_d;
            forfeit_q    <= forfeit_d;
            match_over_q <= match_over_d;
        end
    end

    assign clear_choices = (state_q == S_CLEAR);
    assign busy          = (state_q != S_IDLE);
    assign result_valid  = (state_q == S_REPORT);
    assign result        = result_q;
    assign forfeit       = forfeit_q;
    assign p1_locked     = lock_q[0];
    assign p2_locked     = lock_q[1];
    assign p1_score      = score_q[0];
    assign p2_score      = score_q[1];
    assign match_over    = match_over_q;

endmodule

// File: tb/tb_rps_round_controller.sv
// tb_rps_round_controller: directed bench for rps_round_controller.
// Each scenario task drives vectors and checks hand-computed values.
module tb_rps_round_controller;

    localparam int T = 1000;
    localparam int S = 4;
    localparam int W = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       new_match;
    logic [1:0] p1_choice;
    logic [1:0] p2_choice;
    logic       ack;
    logic       clear_choices;
    logic       busy;
    logic       result_valid;
    logic [1:0] result;
    logic       forfeit;
    logic [1:0] p1_locked;
    logic [1:0] p2_locked;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       match_over;

    int vecs = 0;
    int errs = 0;

    rps_round_controller #(
        .TIMEOUT_CYCLES(T),
        .STABLE_CYCLES (S),
        .WIN_SCORE     (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .new_match    (new_match),
        .p1_choice    (p1_choice),
        .p2_choice    (p2_choice),
        .ack          (ack),
        .clear_choices(clear_choices),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .forfeit      (forfeit),
        .p1_locked    (p1_locked),
        .p2_locked    (p2_locked),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .match_over   (match_over)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts a round with constant choices and waits for REPORT.
    task automatic play(input logic [1:0] a, input logic [1:0] b,
                        input int budget, output int cyc);
        p1_choice = a;
        p2_choice = b;
        ack       = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!result_valid && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    // Acks the result and walks through CLEAR back to IDLE.
    task automatic finish_round(output int pulses);
        pulses = 0;
        ack    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (clear_choices) pulses++;
        end
        ack       = 1'b0;
        p1_choice = 2'd0;
        p2_choice = 2'd0;
    endtask

    task automatic test_reset;
        logic [19:0] got;
        rst_n     = 1'b0;
        start     = 1'b0;
        new_match = 1'b0;
        ack       = 1'b0;
        p1_choice = 2'd0;
        p2_choice = 2'd0;
        tick();
        tick();
        got = {busy, result_valid, clear_choices, forfeit,
               match_over, result, p1_locked, p2_locked,
               p1_score, p2_score, 1'b0};
        vecs++;
        if (got !== 20'd0) begin
            errs++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        rst_n = 1'b1;
        tick();
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic;
        int cyc;
        int p;
        play(2'd1, 2'd3, 100, cyc);
        vecs++;
        if (cyc != S + 3) begin
            errs++;
            $display("FAIL basic_latency: got %0d want %0d",
                     cyc, S + 3);
        end
        vecs++;
        if ({result, forfeit, p1_locked, p2_locked} !==
            {2'd1, 1'b0, 2'd1, 2'd3}) begin
            errs++;
            $display("FAIL basic_result: r=%0d f=%b l=%0d/%0d want 1 0 1/3",
                     result, forfeit, p1_locked, p2_locked);
        end
        vecs++;
        if ({p1_score, p2_score} !== {4'd1, 4'd0}) begin
            errs++;
            $display("FAIL basic_score: got %0d/%0d want 1/0",
                     p1_score, p2_score);
        end
        finish_round(p);
        vecs++;
        if (p != 1) begin
            errs++;
            $display("FAIL basic_clear_pulses: got %0d want 1", p);
        end
        vecs++;
        if ({busy, result_valid, result} !== {1'b0, 1'b0, 2'd1}) begin
            errs++;
            $display("FAIL basic_idle: busy=%b rv=%b r=%0d want 0 0 1",
                     busy, result_valid, result);
        end
    endtask

    task automatic test_judge;
        logic [1:0] ta [3];
        logic [1:0] tb [3];
        logic [1:0] tr [3];
        logic [3:0] s1 [3];
        logic [3:0] s2 [3];
        int cyc;
        int p;
        ta = '{2'd2, 2'd3, 2'd1};
        tb = '{2'd2, 2'd2, 2'd2};
        tr = '{2'd3, 2'd1, 2'd2};
        s1 = '{4'd1, 4'd2, 4'd2};
        s2 = '{4'd0, 4'd0, 4'd1};
        for (int i = 0; i < 3; i++) begin
            play(ta[i], tb[i], 100, cyc);
            vecs++;
            if ({result, forfeit} !== {tr[i], 1'b0}) begin
                errs++;
                $display("FAIL judge_%0d_result: r=%0d f=%b want %0d 0",
                         i, result, forfeit, tr[i]);
            end
            vecs++;
            if ({p1_score, p2_score} !== {s1[i], s2[i]}) begin
                errs++;
                $display("FAIL judge_%0d_score: got %0d/%0d want %0d/%0d",
                         i, p1_score, p2_score, s1[i], s2[i]);
            end
            finish_round(p);
        end
    endtask

    task automatic test_forfeit;
        int cyc;
        int p;
        p1_choice = 2'd1;
        p2_choice = 2'd1;
        ack       = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!result_valid && cyc < T + 20) begin
            if (cyc % 2 == 0) begin
                p1_choice = (p1_choice == 2'd1) ? 2'd2 : 2'd1;
            end
            tick();
            cyc++;
        end
        vecs++;
        if (cyc != T + 1) begin
            errs++;
            $display("FAIL forfeit_p2_latency: got %0d want %0d",
                     cyc, T + 1);
        end
        vecs++;
        if ({result, forfeit, p1_locked, p2_locked} !==
            {2'd2, 1'b1, 2'd0, 2'd1}) begin
            errs++;
            $display("FAIL forfeit_p2_result: r=%0d f=%b l=%0d/%0d want 2 1 0/1",
                     result, forfeit, p1_locked, p2_locked);
        end
        vecs++;
        if ({p1_score, p2_score} !== {4'd2, 4'd2}) begin
            errs++;
            $display("FAIL forfeit_p2_score: got %0d/%0d want 2/2",
                     p1_score, p2_score);
        end
        finish_round(p);

        play(2'd0, 2'd0, T + 20, cyc);
        vecs++;
        if (cyc != T + 1) begin
            errs++;
            $display("FAIL forfeit_none_latency: got %0d want %0d",
                     cyc, T + 1);
        end
        vecs++;
        if ({result, forfeit, p1_locked, p2_locked} !==
            {2'd0, 1'b1, 2'd0, 2'd0}) begin
            errs++;
            $display("FAIL forfeit_none_result: r=%0d f=%b l=%0d/%0d want 0 1 0/0",
                     result, forfeit, p1_locked, p2_locked);
        end
        vecs++;
        if ({p1_score, p2_score} !== {4'd2, 4'd2}) begin
            errs++;
            $display("FAIL forfeit_none_score: got %0d/%0d want 2/2",
                     p1_score, p2_score);
        end
        finish_round(p);
    endtask

    task automatic test_match;
        logic [1:0] ta [3];
        logic [1:0] tb [3];
        int cyc;
        int p;
        ta = '{2'd1, 2'd2, 2'd3};
        tb = '{2'd2, 2'd3, 2'd1};
        new_match = 1'b1;
        tick();
        new_match = 1'b0;
        vecs++;
        if ({p1_score, p2_score, match_over} !== 9'd0) begin
            errs++;
            $display("FAIL new_match_clear: got %0d/%0d mo=%b want 0/0 0",
                     p1_score, p2_score, match_over);
        end
        for (int i = 0; i < 3; i++) begin
            play(ta[i], tb[i], 100, cyc);
            vecs++;
            if ({result, p2_score, match_over} !==
                {2'd2, 4'(i + 1), (i == 2)}) begin
                errs++;
                $display("FAIL match_%0d: r=%0d p2=%0d mo=%b want 2 %0d %0d",
                         i, result, p2_score, match_over, i + 1,
                         (i == 2));
            end
            finish_round(p);
        end
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vecs++;
            if (busy !== 1'b0) begin
                errs++;
                $display("FAIL match_over_start_%0d: busy=%b want 0",
                         i, busy);
            end
        end
        new_match = 1'b1;
        tick();
        new_match = 1'b0;
        start     = 1'b0;
        vecs++;
        if ({busy, p1_score, p2_score, match_over} !== 10'd0) begin
            errs++;
            $display("FAIL new_match_priority: busy=%b s=%0d/%0d mo=%b want 0 0/0 0",
                     busy, p1_score, p2_score, match_over);
        end
        tick();
    endtask

    task automatic test_ack_hold;
        int cyc;
        int p;
        play(2'd2, 2'd1, 100, cyc);
        vecs++;
        if ({result, p1_score, p2_score} !== {2'd1, 4'd1, 4'd0}) begin
            errs++;
            $display("FAIL hold_result: r=%0d s=%0d/%0d want 1 1/0",
                     result, p1_score, p2_score);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            vecs++;
            if ({result_valid, clear_choices} !== 2'b10) begin
                errs++;
                $display("FAIL hold_cycle_%0d: rv=%b cc=%b want 1 0",
                         i, result_valid, clear_choices);
            end
        end
        finish_round(p);
        vecs++;
        if (p != 1) begin
            errs++;
            $display("FAIL hold_clear_pulses: got %0d want 1", p);
        end
    endtask

    task automatic test_async_reset;
        logic [19:0] got;
        int cyc;
        int p;
        p1_choice = 2'd3;
        p2_choice = 2'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL async_pre_busy: busy=%b want 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {busy, result_valid, clear_choices, forfeit,
               match_over, result, p1_locked, p2_locked,
               p1_score, p2_score, 1'b0};
        vecs++;
        if (got !== 20'd0) begin
            errs++;
            $display("FAIL async_reset_outputs: got %h want 0", got);
        end
        tick();
        rst_n     = 1'b1;
        p1_choice = 2'd0;
        p2_choice = 2'd0;
        tick();
        vecs++;
        if ({busy, clear_choices} !== 2'b00) begin
            errs++;
            $display("FAIL async_reset_idle: busy=%b cc=%b want 0 0",
                     busy, clear_choices);
        end
        play(2'd3, 2'd3, 100, cyc);
        vecs++;
        if ({result, p1_score, p2_score} !== {2'd3, 4'd0, 4'd0}) begin
            errs++;
            $display("FAIL async_recover: r=%0d s=%0d/%0d want 3 0/0",
                     result, p1_score, p2_score);
        end
        finish_round(p);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_judge();
        test_forfeit();
        test_match();
        test_ack_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
